// File: rtl/snn_fixed_pkg.sv
// Shared fixed-point definitions for the spiking-neuron datapath (Q2.16 by default).
package snn_fixed_pkg;

  localparam int N_DEF     = 18;
  localparam int FRAC_BITS = 16;

  localparam logic signed [N_DEF-1:0] Q_ONE = 18'sh1_0000;
  localparam logic signed [N_DEF-1:0] Q_MAX = 18'sh1_FFFF;
  localparam logic signed [N_DEF-1:0] Q_MIN = 18'sh2_0000;

  typedef enum logic [1:0] {IDLE, SCAN, OUT} state_e;

  // Saturated add at the default width; an overflow shows up as disagreement
  // between the two top bits of the one-bit-wider sum.
  function automatic logic signed [N_DEF-1:0] sat_add(input logic signed [N_DEF-1:0] a,
                                                      input logic signed [N_DEF-1:0] b);
    logic signed [N_DEF:0] s;
    s = {a[N_DEF-1], a} + {b[N_DEF-1], b};
    if (s[N_DEF] != s[N_DEF-1]) return s[N_DEF] ? Q_MIN : Q_MAX;
    return s[N_DEF-1:0];
  endfunction

endpackage

// File: rtl/synapse_weight_mem.sv
// Synaptic weight register file: one synchronous write port, one combinational
// read port, cleared synchronously on reset.
module synapse_weight_mem #(
  parameter int N          = 18,
  parameter int NUM_INPUTS = 8,
  parameter int AW         = $clog2(NUM_INPUTS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic signed [N-1:0] wdata_i,
  input  logic [AW-1:0]       raddr_i,
  output logic signed [N-1:0] rdata_o
);

  logic signed [N-1:0] mem_q [NUM_INPUTS];

  // Write port; a read of the address being written still sees the old value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_INPUTS; i++) mem_q[i] <= '0;
    end else if (we_i && (32'(waddr_i) < NUM_INPUTS)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/synaptic_current_integrator.sv
// Synaptic current integrator: per timestep decays the stored current, adds the
// weight of every spiking input (one input per clock, index 0 first, saturating
// after each add), then presents the current plus bias to the neuron core.
module synaptic_current_integrator
  import snn_fixed_pkg::*;
#(
  parameter  int N           = 18,
  parameter  int NUM_INPUTS  = 8,
  parameter  int DECAY_SHIFT = 3,
  localparam int AW          = $clog2(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step,
  input  logic [NUM_INPUTS-1:0] pre_spikes,
  input  logic                  w_we,
  input  logic [AW-1:0]         w_addr,
  input  logic signed [N-1:0]   w_data,
  input  logic signed [N-1:0]   i_bias,
  output logic signed [N-1:0]   i_out,
  output logic                  i_valid,
  output logic                  busy
);

  // Saturated add at the instance width: sum in N+1 bits, clamp on overflow.
  function automatic logic signed [N-1:0] sat_add_n(input logic signed [N-1:0] a,
                                                    input logic signed [N-1:0] b);
    logic signed [N:0] s;
    s = {a[N-1], a} + {b[N-1], b};
    if (s[N] != s[N-1]) return s[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    return s[N-1:0];
  endfunction

  state_e                  state_q, state_d;
  logic [NUM_INPUTS-1:0]   snap_q, snap_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic signed [N-1:0]     acc_q, acc_d;
  logic signed [N-1:0]     isyn_q, isyn_d;
  logic signed [N-1:0]     iout_q, iout_d;
  logic                    ivalid_q, ivalid_d;
  logic signed [N-1:0]     w_rd;

  synapse_weight_mem #(
    .N          (N),
    .NUM_INPUTS (NUM_INPUTS),
    .AW         (AW)
  ) u_wmem (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (w_we),
    .waddr_i (w_addr),
    .wdata_i (w_data),
    .raddr_i (idx_q),
    .rdata_o (w_rd)
  );

  // Next-state logic: IDLE waits for step, SCAN walks the snapshot, OUT publishes.
  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    isyn_d   = isyn_q;
    iout_d   = iout_q;
    ivalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (step) begin
          snap_d  = pre_spikes;
          // Decay only shrinks the magnitude, so no saturation is needed here.
          acc_d   = isyn_q - (isyn_q >>> DECAY_SHIFT);
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (snap_q[idx_q]) acc_d = sat_add_n(acc_q, w_rd);
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(NUM_INPUTS - 1)) state_d = OUT;
      end
      OUT: begin
        isyn_d   = acc_q;
        iout_d   = sat_add_n(acc_q, i_bias);
        ivalid_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset also aborts any scan in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      snap_q   <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      isyn_q   <= '0;
      iout_q   <= '0;
      ivalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      isyn_q   <= isyn_d;
      iout_q   <= iout_d;
      ivalid_q <= ivalid_d;
    end
  end

  assign i_out   = iout_q;
  assign i_valid = ivalid_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_synaptic_current_integrator.sv
// Bench for synaptic_current_integrator: directed vector table, control corner
// sequences and randomized timesteps checked against an arithmetic model.
module tb_synaptic_current_integrator;

  localparam int N  = 18;
  localparam int NI = 8;
  localparam int AW = 3;
  localparam int QMAX = 131071;
  localparam int QMIN = -131072;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 step = 1'b0;
  logic [NI-1:0]        pre_spikes = '0;
  logic                 w_we = 1'b0;
  logic [AW-1:0]        w_addr = '0;
  logic signed [N-1:0]  w_data = '0;
  logic signed [N-1:0]  i_bias = '0;
  logic signed [N-1:0]  i_out;
  logic                 i_valid;
  logic                 busy;

  synaptic_current_integrator #(
    .N           (N),
    .NUM_INPUTS  (NI),
    .DECAY_SHIFT (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .step       (step),
    .pre_spikes (pre_spikes),
    .w_we       (w_we),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .i_bias     (i_bias),
    .i_out      (i_out),
    .i_valid    (i_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: stored synaptic current and weights as plain integers.
  int m_isyn;
  int m_w [NI];

  function automatic int clampq(input int x);
    if (x > QMAX) return QMAX;
    if (x < QMIN) return QMIN;
    return x;
  endfunction

  function automatic int floordiv(input int x, input int d);
    int q;
    q = x / d;
    if (x < 0 && (x % d) != 0) q = q - 1;
    return q;
  endfunction

  function automatic int s18(input logic [N-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int model_step(input logic [NI-1:0] sp, input int bias);
    int acc;
    acc = m_isyn - floordiv(m_isyn, 8);
    for (int k = 0; k < NI; k++)
      if (sp[k]) acc = clampq(acc + m_w[k]);
    m_isyn = acc;
    return clampq(acc + bias);
  endfunction

  task automatic model_reset();
    m_isyn = 0;
    for (int k = 0; k < NI; k++) m_w[k] = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%05h) required=%0d (0x%05h)", name, act, act[17:0], exp, exp[17:0]);
    end
  endtask

  task automatic bench_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wr(input int addr, input int val);
    @(negedge clk);
    w_we   = 1'b1;
    w_addr = addr[AW-1:0];
    w_data = val[N-1:0];
    @(negedge clk);
    w_we   = 1'b0;
    m_w[addr] = val;
  endtask

  // Issues one step and watches a 20-cycle window. Cycle 0 is the first
  // negedge after the accepting posedge. Optionally re-asserts step or pulses
  // reset at a given window cycle; pre_spikes is scrambled after acceptance.
  task automatic do_step(input logic [NI-1:0] sp, input int bias,
                         input int restep_at, input int rst_at,
                         output int outv, output int outend, output int lat,
                         output int npulse, output int busy_bad);
    @(negedge clk);
    step       = 1'b1;
    pre_spikes = sp;
    i_bias     = bias[N-1:0];
    @(negedge clk);
    step     = 1'b0;
    lat      = -1;
    npulse   = 0;
    busy_bad = 0;
    outv     = 0;
    for (int c = 0; c < 20; c++) begin
      if (c <= 9 && rst_at < 0 && busy !== 1'(c <= 8)) busy_bad++;
      if (i_valid === 1'b1) begin
        npulse++;
        if (lat < 0) begin
          lat  = c;
          outv = s18(i_out);
        end
      end
      step       = (c == restep_at);
      reset      = (c == rst_at);
      pre_spikes = NI'($urandom);
      @(negedge clk);
    end
    step   = 1'b0;
    reset  = 1'b0;
    outend = s18(i_out);
    if (lat < 0) outv = outend;
  endtask

  typedef struct {
    bit          rst;
    bit          dostep;
    logic [7:0]  wmask;
    int          wval;
    logic [7:0]  sp;
    int          bias;
    int          exp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int outv, outend, lat, np, bb, expv;

    tbl[0] = '{1'b1, 1'b1, 8'h00, 0,         8'h00, 'h2666, 'h2666};
    tbl[1] = '{1'b1, 1'b1, 8'h01, 'h4000,    8'h01, 0,      'h4000};
    tbl[2] = '{1'b0, 1'b1, 8'h00, 0,         8'h00, 0,      'h3800};
    tbl[3] = '{1'b0, 1'b1, 8'h00, 0,         8'h00, 0,      'h3100};
    tbl[4] = '{1'b1, 1'b1, 8'hFF, 'h8000,    8'hFF, 0,      'h1FFFF};
    tbl[5] = '{1'b0, 1'b1, 8'h00, 0,         8'h00, 0,      'h1C000};
    tbl[6] = '{1'b1, 1'b1, 8'hFF, -'h10000,  8'hFF, 0,      -'h20000};
    tbl[7] = '{1'b1, 1'b0, 8'h01, 'h18000,   8'h00, 0,      0};
    tbl[8] = '{1'b0, 1'b0, 8'h02, 'h10000,   8'h00, 0,      0};
    tbl[9] = '{1'b0, 1'b1, 8'h04, -'h10000,  8'h07, 0,      'hFFFF};

    model_reset();
    bench_reset();
    #1;
    chk("reset_i_out", s18(i_out), 0);
    chk("reset_i_valid", int'(i_valid), 0);
    chk("reset_busy", int'(busy), 0);

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst) bench_reset();
      for (int k = 0; k < NI; k++)
        if (tbl[i].wmask[k]) wr(k, tbl[i].wval);
      if (tbl[i].dostep) begin
        do_step(tbl[i].sp, tbl[i].bias, -1, -1, outv, outend, lat, np, bb);
        expv = model_step(tbl[i].sp, tbl[i].bias);
        chk($sformatf("vec%0d_out", i), outv, tbl[i].exp);
        chk($sformatf("vec%0d_hold", i), outend, tbl[i].exp);
        chk($sformatf("vec%0d_latency", i), lat, 9);
        chk($sformatf("vec%0d_pulses", i), np, 1);
        chk($sformatf("vec%0d_busy", i), bb, 0);
      end
    end

    // Second step while busy is ignored
    bench_reset();
    for (int k = 0; k < NI; k++) wr(k, int'($urandom_range(0, 'h7FFF)) - 'h4000);
    do_step(8'hA5, 'h0123, 3, -1, outv, outend, lat, np, bb);
    expv = model_step(8'hA5, 'h0123);
    chk("restep_out", outv, expv);
    chk("restep_pulses", np, 1);
    chk("restep_latency", lat, 9);
    chk("restep_busy", bb, 0);

    // Reset in the middle of a scan aborts and clears the weights
    for (int k = 0; k < NI; k++) wr(k, 'h1000);
    do_step(8'hFF, 'h1234, -1, 4, outv, outend, lat, np, bb);
    model_reset();
    chk("midrst_pulses", np, 0);
    chk("midrst_i_out", outend, 0);
    do_step(8'hFF, 'h1234, -1, -1, outv, outend, lat, np, bb);
    expv = model_step(8'hFF, 'h1234);
    chk("postrst_out", outv, 'h1234);
    chk("postrst_latency", lat, 9);

    // Randomized timesteps against the model
    bench_reset();
    for (int r = 0; r < 40; r++) begin
      int nw;
      logic [NI-1:0] sp;
      int bias;
      nw = int'($urandom_range(0, 3));
      for (int j = 0; j < nw; j++)
        wr(int'($urandom_range(0, NI-1)), int'($urandom_range(0, 262143)) - 131072);
      sp   = NI'($urandom);
      bias = int'($urandom_range(0, 65535)) - 32768;
      do_step(sp, bias, -1, -1, outv, outend, lat, np, bb);
      expv = model_step(sp, bias);
      chk($sformatf("rand%0d_out", r), outv, expv);
      chk($sformatf("rand%0d_latency", r), lat, 9);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/synaptic_current_integrator.md
Name: synaptic_current_integrator

Overview:
Upstream stage of the Izhikevich neuron core. It turns a vector of presynaptic spike bits into the signed input current `i` that the core consumes each timestep. Per timestep it does three things: decays the stored synaptic current, adds the programmable weights of every input that spiked, and adds a bias. One input is scanned per clock, so one adder serves all synapses. Fixed-point format matches the core: 18-bit two's complement, 16 fractional bits, 1.0 = 18'sh1_0000, range [-2.0, 2.0).

Parameters:
N, 18, data width in bits (Q2.16 when N=18)
NUM_INPUTS, 8, number of presynaptic inputs (>=2)
DECAY_SHIFT, 3, per-step decay: i_syn -= i_syn >>> DECAY_SHIFT
AW, $clog2(NUM_INPUTS), weight address width (derived; not overridden)

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high
step  in  1  start-of-timestep strobe; accepted only when busy=0
pre_spikes  in  NUM_INPUTS  presynaptic spike bits; sampled on the accepted step
w_we  in  1  weight write enable
w_addr  in  AW  weight index
w_data  in  N  signed weight
i_bias  in  N  signed bias current; sampled in OUT state
i_out  out  N  signed current to the neuron core; held between updates
i_valid  out  1  one-cycle pulse when i_out updates
busy  out  1  high from the cycle after step is accepted until the OUT cycle inclusive

Behaviour:
- Reset (synchronous): state=IDLE; i_syn=0, acc=0, idx=0; i_out=0, i_valid=0, busy=0; all weights cleared to 0.
- State IDLE, step=1:
  - Latch pre_spikes into snap.
  - acc <= i_syn - (i_syn >>> DECAY_SHIFT), arithmetic shift.
  - idx <= 0; go to SCAN.
- State IDLE, step=0: stay in IDLE.
- State SCAN: one index per cycle.
  - If snap[idx], acc <= sat(acc + w[idx]).
  - idx increments; after idx = NUM_INPUTS-1, go to OUT.
- State OUT (one cycle):
  - i_syn <= acc.
  - i_out <= sat(acc + i_bias).
  - i_valid <= 1 (asserted for exactly this one cycle).
  - Go to IDLE.
- Latency: step accepted at cycle t -> i_valid high and i_out updated at cycle t+NUM_INPUTS+1. Back-to-back step gives one update per NUM_INPUTS+2 cycles.
- step while busy=1: ignored; no queuing.
- Changes to pre_spikes after acceptance: no effect on the current step.
- sat(): sum formed in N+1 bits, clamped to [-2^(N-1), 2^(N-1)-1], i.e. 18'sh2_0000 .. 18'sh1_FFFF. Saturation applies after every add, so the result depends on scan order (index 0 first).
- Weight writes:
  - Accepted in any state; take effect on the next clock.
  - A SCAN read of the same address in the write cycle returns the old value.
- Reset mid-SCAN: aborts immediately; no i_valid; weights cleared.
- i_out holds its last value while IDLE/SCAN; the core samples it on i_valid.

Decomposition:
- Package snn_fixed_pkg:
  - Constants: N default, FRAC_BITS=16, Q_ONE=18'sh1_0000, Q_MAX, Q_MIN.
  - Function sat_add(a, b) returning a saturated N-bit sum.
  - State enum {IDLE, SCAN, OUT}.
- One sub-module: synapse_weight_mem.
  - NUM_INPUTS x N register file.
  - One synchronous write port, one combinational read port.
  - Synchronous clear on reset.

Test Plan:
- Reset, all weights 0, i_bias=18'sh0_2666, step with pre_spikes=0 -> i_valid exactly 9 cycles after step (NUM_INPUTS=8); i_out=18'sh0_2666; busy high for those cycles.
- w[0]=18'sh0_4000, i_bias=0, step with pre_spikes=8'h01 -> i_out=18'sh0_4000. Next step, no spikes -> i_out=18'sh0_3800 (decay by 1/8). Step after that -> 18'sh0_3100.
- All weights 18'sh0_8000 (0.5), pre_spikes=8'hFF, step -> i_out=18'sh1_FFFF (positive clamp); i_syn holds 18'sh1_FFFF.
- After reset, all weights 18'sh3_0000 (-1.0), pre_spikes=8'hFF -> i_out=18'sh2_0000 (negative clamp).
- Mixed-sign order check: w[0]=18'sh1_8000, w[1]=18'sh1_0000, w[2]=18'sh3_0000, pre_spikes=8'h07, i_bias=0 -> i_out=18'sh0_FFFF (clamp at w[1], then -1.0).
- Control edge cases:
  - step asserted again 3 cycles after acceptance -> ignored; exactly one i_valid.
  - reset pulsed 4 cycles into SCAN -> no i_valid; i_out=0; weights read back 0 via a subsequent all-spike step giving i_out=i_bias.
